// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with a small register file.
// Define SEG_LZB_EN to enable leading-zero blanking of digits 1..7.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [7:0]  dig_en,
  output logic        DN_A,
  output logic        DN_B,
  output logic        DN_C,
  output logic        DN_D,
  output logic        DN_E,
  output logic        DN_F,
  output logic        DN_G,
  output logic        DN_DP
);

  localparam int unsigned CW =
    (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SCAN_DIV - 1);

  typedef enum logic {
    SHOW,
    BLANK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;

  logic [31:0] data_q, data_d;
  logic [7:0]  en_q, en_d;
  logic [7:0]  dp_q, dp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [7:0]  dig_q, dig_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpo_q, dpo_d;

  logic [3:0]  nib;
  logic        lz_blank;
  logic        digit_on;

  // Segment pattern, active-high, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_seg(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        idx_d   = idx_q + 3'd1;
        state_d = SHOW;
      end
    endcase
  end

  always_comb begin
    data_d = data_q;
    en_d   = en_q;
    dp_d   = dp_q;
    if (bus_we) begin
      unique case (bus_addr)
        2'd0: data_d = bus_wdata;
        2'd1: en_d   = bus_wdata[7:0];
        2'd2: dp_d   = bus_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    unique case (bus_addr)
      2'd0: rdata_d = data_q;
      2'd1: rdata_d = {24'd0, en_q};
      2'd2: rdata_d = {24'd0, dp_q};
      default: rdata_d = {27'd0,
                          state_q == BLANK,
                          idx_q,
                          en_q != 8'd0};
    endcase
  end

  assign nib = 4'(data_q >> {idx_q, 2'b00});

`ifdef SEG_LZB_EN
  // Digit 0 always shows, so a zero value reads "0"
  assign lz_blank = (idx_q != 3'd0) &&
    ((data_q >> {idx_q, 2'b00}) == 32'd0);
`else
  assign lz_blank = 1'b0;
`endif

  assign digit_on = (state_q == SHOW) &&
    en_q[idx_q] && !lz_blank;

  always_comb begin
    dig_d = 8'hFF;
    seg_d = 7'h7F;
    dpo_d = 1'b1;
    if (digit_on) begin
      dig_d = ~(8'h01 << idx_q);
      seg_d = ~hex_seg(nib);
      dpo_d = ~dp_q[idx_q];
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 32'd0;
      en_q    <= 8'hFF;
      dp_q    <= 8'd0;
      rdata_q <= 32'd0;
      dig_q   <= 8'hFF;
      seg_q   <= 7'h7F;
      dpo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      rdata_q <= rdata_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign dig_en    = dig_q;
  assign DN_A      = seg_q[0];
  assign DN_B      = seg_q[1];
  assign DN_C      = seg_q[2];
  assign DN_D      = seg_q[3];
  assign DN_E      = seg_q[4];
  assign DN_F      = seg_q[5];
  assign DN_G      = seg_q[6];
  assign DN_DP     = dpo_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 20000, giving clock cycles per digit in the SHOW state (legal range 2..2^20).
REQ-002 SHALL have port fpga_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port fpga_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port bus_we  input  1  register write strobe, one write per cycle.
REQ-005 SHALL have port bus_addr  input  2  register select: 0=DATA, 1=EN_MASK, 2=DP_MASK, 3=STATUS (read-only).
REQ-006 SHALL have port bus_wdata  input  32  write data.
REQ-007 SHALL have port bus_rdata  output  32  registered readback of the register at bus_addr.
REQ-008 SHALL have port dig_en  output  8  digit enables, active-low, bit i = digit i.
REQ-009 SHALL have ports DN_A..DN_G, DN_DP  output  1 each  segment drives, active-low.

Function
REQ-010 SHALL hold DATA[31:0] (digit i = nibble DATA[4i+3:4i]), EN_MASK[7:0] and DP_MASK[7:0]; writes take effect the cycle after bus_we.
REQ-011 SHALL ignore writes to address 3; bits above [7:0] of EN_MASK and DP_MASK SHALL be dropped on write and read back as 0.
REQ-012 SHALL return bus_rdata one cycle after bus_addr is presented; STATUS = {27'b0, state==BLANK, idx[2:0], busy}, where busy=1 when EN_MASK!=0.
REQ-013 SHALL use FSM states SHOW and BLANK, with a scan counter cnt and a digit index idx[2:0].
REQ-014 In SHOW, cnt SHALL increment each cycle; at cnt==SCAN_DIV-1, cnt SHALL clear and the FSM SHALL move to BLANK.
REQ-015 BLANK SHALL last exactly one cycle, during which idx SHALL increment with wrap 7->0; the FSM SHALL then return to SHOW, giving a per-digit period of SCAN_DIV+1 cycles.
REQ-016 Outputs SHALL be registered, so that outputs in cycle n+1 reflect the state, idx and registers of cycle n.
REQ-017 In BLANK, dig_en SHALL be 8'hFF and all segments 1 (anti-ghosting).
REQ-018 In SHOW with EN_MASK[idx]=1, dig_en SHALL be ~(8'h01<<idx), segments SHALL be the hex-decode of nibble idx (0-F; b/d lowercase), and DN_DP SHALL be ~DP_MASK[idx].
REQ-019 In SHOW with EN_MASK[idx]=0, dig_en SHALL be 8'hFF and segments all 1, and scanning timing SHALL be unchanged.
REQ-020 On a write coinciding with the SHOW->BLANK or BLANK->SHOW transition, the new register value SHALL be used from the next cycle; no digit is skipped or repeated.
REQ-021 SHALL keep scanning continuously while EN_MASK==0; only the outputs are blanked.

Reset
REQ-022 While fpga_rst=1 at a clock edge, the block SHALL set state=SHOW, cnt=0, idx=0, DATA=0, EN_MASK=8'hFF, DP_MASK=0, bus_rdata=0, dig_en=8'hFF and all segments=1.
REQ-023 Reset asserted mid-scan SHALL take effect at the next edge regardless of state or pending write (reset wins over bus_we).
REQ-024 On the first cycle after reset release, outputs SHALL show digit 0 as "0" (dig_en=8'hFE, DN_A..DN_F=0, DN_G=1, DN_DP=1).

Configuration
REQ-025 Macro SEG_LZB_EN SHALL, when defined, enable leading-zero blanking: in SHOW, digit idx>0 is forced off (as in REQ-019) when DATA[31:4*idx]==0; digit 0 is never LZB-blanked.
REQ-026 Without SEG_LZB_EN, all digits with EN_MASK set SHALL display, including leading zeros; the LZB logic SHALL not be synthesized.

Verification (SCAN_DIV=4 in bench)
REQ-027 Reset, then release -> dig_en=FE with segments "0"; after 4 cycles one cycle of dig_en=FF; then dig_en=FD; full sweep 7->0 wrap after 40 cycles.
REQ-028 Write DATA=32'h2012_3456 -> digit 0 shows "6", digit 7 shows "2"; read addr 0 one cycle later -> bus_rdata=32'h2012_3456.
REQ-029 Write EN_MASK=8'h0F and DP_MASK=8'h02 -> digits 4-7 stay dig_en=FF in their slots; DN_DP=0 only while dig_en=FD.
REQ-030 Assert fpga_rst while idx=5 in SHOW together with bus_we=1 -> next cycle DATA=0, idx=0, dig_en=FF; the write is discarded.
REQ-031 With SEG_LZB_EN defined and DATA=32'h0000_00A0 -> only digits 0 ("0") and 1 ("A") light; without the macro all 8 light.
REQ-032 Write coinciding with the BLANK cycle -> the following SHOW digit displays the new nibble, and the period remains 5 cycles.
